// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: state encoding, record widths and timing defaults shared by freq_meas_sched.
package freq_meas_pkg;
   typedef enum logic [2:0] {IDLE, SELECT, ARM, COUNT, DONE} state_t;
   localparam int DEF_SYS_CLK_FREQ = 200_000_000;
   localparam int DEF_CNT_W = 32;
   localparam int NPER_W = 8;
   localparam int TIMEOUT_DIV = 10;
   localparam int DEF_TIMEOUT_CYC = DEF_SYS_CLK_FREQ / TIMEOUT_DIV;
   function automatic int ch_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/wave_edge_sync.sv
// wave_edge_sync: 2-FF synchroniser for one asynchronous square wave, with synced level and rising-edge pulse.
module wave_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic wave_i,
   output logic level_o,
   output logic rise_o
);
   logic [2:0] sync_q;
   logic rise_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], wave_i};
         rise_q <= sync_q[1] & ~sync_q[2];
      end
   end
   // level is delayed one stage so it turns high in the same cycle as the rise pulse
   assign level_o = sync_q[2];
   assign rise_o = rise_q;
endmodule

// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin period/duty measurement sequencer over CH_NUM square-wave inputs.
// Build with FREQ_MEAS_DUTY_EN defined to include the high-time accumulator; otherwise res_high is 0.
module freq_meas_sched
   import freq_meas_pkg::*;
#(
   parameter int SYS_CLK_FREQ = DEF_SYS_CLK_FREQ,
   parameter int CH_NUM = 2,
   parameter int CNT_W = DEF_CNT_W,
   parameter int TIMEOUT_CYC = SYS_CLK_FREQ / TIMEOUT_DIV
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic [CH_NUM-1:0] wave_in,
   input  logic start,
   input  logic continuous,
   input  logic [CH_NUM-1:0] ch_mask,
   input  logic [NPER_W-1:0] n_periods,
   output logic busy,
   output logic res_valid,
   input  logic res_ready,
   output logic [ch_w(CH_NUM)-1:0] res_ch,
   output logic [CNT_W-1:0] res_period,
   output logic [CNT_W-1:0] res_high,
   output logic res_timeout
);
   localparam int CHW = ch_w(CH_NUM);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   state_t state_q, state_d;
   logic [CH_NUM-1:0] mask_q, mask_d, pend_q, pend_d, lvl_w, rise_w;
   logic [CHW-1:0] ch_q, ch_d, sel;
   logic [NPER_W-1:0] n_q, n_d, ecnt_q, ecnt_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic tout_q, tout_d, tmo_hit, rise;
   for (genvar i = 0; i < CH_NUM; i++) begin : g_sync
      wave_edge_sync u_sync (
         .clk_i(sys_clk),
         .rst_i(sys_rst),
         .wave_i(wave_in[i]),
         .level_o(lvl_w[i]),
         .rise_o(rise_w[i])
      );
   end
   assign rise = rise_w[ch_q];
   assign tmo_hit = tmo_q == TW'(TIMEOUT_CYC);
   always_comb begin
      state_d = state_q;
      mask_d = mask_q;
      pend_d = pend_q;
      ch_d = ch_q;
      n_d = n_q;
      ecnt_d = ecnt_q;
      tmo_d = tmo_q;
      per_d = per_q;
      tout_d = tout_q;
      sel = '0;
      // only unserved channels stay pending, so the lowest pending bit is the next one upward
      for (int i = CH_NUM - 1; i >= 0; i--) if (pend_q[i]) sel = CHW'(i);
      case (state_q)
         IDLE: if (start && |ch_mask) begin
            state_d = SELECT;
            mask_d = ch_mask;
            pend_d = ch_mask;
            n_d = n_periods == '0 ? NPER_W'(1) : n_periods;
         end
         SELECT: begin
            state_d = ARM;
            ch_d = sel;
            pend_d = pend_q & ~(CH_NUM'(1) << sel);
            ecnt_d = '0;
            tmo_d = '0;
            per_d = '0;
            tout_d = 1'b0;
         end
         ARM: begin
            state_d = tmo_hit ? DONE : rise ? COUNT : ARM;
            tout_d = tmo_hit;
            tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
         end
         COUNT: if (tmo_hit) begin
            state_d = DONE;
            tout_d = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
            per_d = &per_q ? per_q : per_q + 1'b1;
            ecnt_d = rise ? ecnt_q + 1'b1 : ecnt_q;
            state_d = rise && ecnt_q + 1'b1 == n_q ? DONE : COUNT;
         end
         DONE: if (res_ready) begin
            state_d = |pend_q || continuous ? SELECT : IDLE;
            pend_d = |pend_q ? pend_q : continuous ? mask_q : pend_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         mask_q <= '0;
         pend_q <= '0;
         ch_q <= '0;
         n_q <= '0;
         ecnt_q <= '0;
         tmo_q <= '0;
         per_q <= '0;
         tout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q <= mask_d;
         pend_q <= pend_d;
         ch_q <= ch_d;
         n_q <= n_d;
         ecnt_q <= ecnt_d;
         tmo_q <= tmo_d;
         per_q <= per_d;
         tout_q <= tout_d;
      end
   end
`ifdef FREQ_MEAS_DUTY_EN
   logic [CNT_W-1:0] high_q, high_d;
   always_comb high_d = state_q == SELECT ? '0 :
      state_q == COUNT && !tmo_hit && lvl_w[ch_q] && !(&high_q) ? high_q + 1'b1 : high_q;
   always_ff @(posedge sys_clk) begin
      if (sys_rst) high_q <= '0;
      else high_q <= high_d;
   end
   assign res_high = high_q;
`else
   logic lvl_unused;
   assign lvl_unused = ^lvl_w;
   assign res_high = '0;
`endif
   assign busy = state_q != IDLE;
   assign res_valid = state_q == DONE;
   assign res_ch = ch_q;
   assign res_period = per_q;
   assign res_timeout = tout_q;
endmodule

// File: tb/tb_freq_meas_sched.sv
// tb_freq_meas_sched: directed bench with a record-level reference model and a per-cycle checker.
module tb_freq_meas_sched;
   localparam int CH = 2;
   localparam int TMO = 100;
`ifdef FREQ_MEAS_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif
   typedef struct {int ch; longint per; longint high; bit tmo;} rec_t;
   logic sys_clk = 1'b0, sys_rst = 1'b1, start = 1'b0, continuous = 1'b0, res_ready = 1'b0;
   logic [CH-1:0] wave_in = '0, ch_mask = '0;
   logic [7:0] n_periods = '0;
   logic busy, res_valid, res_timeout;
   logic [0:0] res_ch;
   logic [31:0] res_period, res_high;
   rec_t exp_q[$];
   int n_chk = 0, n_fail = 0, hs_cnt = 0;
   int per_c[CH], hi_c[CH], ph[CH];

   freq_meas_sched #(.CH_NUM(CH), .CNT_W(32), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .wave_in(wave_in), .start(start),
      .continuous(continuous), .ch_mask(ch_mask), .n_periods(n_periods), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch), .res_period(res_period),
      .res_high(res_high), .res_timeout(res_timeout)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // expected record of a clean wave with period p and high time h measured over n periods
   function automatic rec_t meas(input int ch, input int p, input int h, input int n);
      int nn;
      rec_t r;
      nn = n == 0 ? 1 : n;
      r.ch = ch;
      r.per = longint'(nn * p);
      r.high = DUTY ? longint'(nn * h) : 0;
      r.tmo = 1'b0;
      return r;
   endfunction

   function automatic rec_t lit(input int ch, input int p, input int h, input bit t);
      rec_t r;
      r.ch = ch;
      r.per = p;
      r.high = DUTY ? h : 0;
      r.tmo = t;
      return r;
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic set_wave(input int c, input int p, input int h);
      per_c[c] = p;
      hi_c[c] = h;
      ph[c] = 0;
   endtask

   task automatic go(input logic [CH-1:0] m, input logic [7:0] n);
      ch_mask = m;
      n_periods = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_busy_low(input int lim, input string nm);
      int k = 0;
      while (busy && k < lim) begin
         tick();
         k++;
      end
      check(nm, busy, 0);
   endtask

   task automatic wait_valid(input int lim, input string nm);
      int k = 0;
      while (!res_valid && k < lim) begin
         tick();
         k++;
      end
      check(nm, res_valid, 1);
   endtask

   // square-wave generators, one phase counter per channel; period 0 holds the line low
   initial forever begin
      @(posedge sys_clk);
      #2;
      for (int c = 0; c < CH; c++) begin
         if (per_c[c] == 0) wave_in[c] = 1'b0;
         else begin
            ph[c] = (ph[c] + 1) % per_c[c];
            wave_in[c] = ph[c] < hi_c[c];
         end
      end
   end

   // checker: every handshake consumes one expected record; a stalled record must hold still
   initial begin
      rec_t e;
      logic stall;
      logic [0:0] h_ch;
      logic [31:0] h_per, h_high;
      logic h_tmo;
      stall = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (sys_rst) stall = 1'b0;
         else begin
            if (stall) begin
               check("hold_valid", res_valid, 1);
               check("hold_ch", res_ch, h_ch);
               check("hold_period", res_period, h_per);
               check("hold_high", res_high, h_high);
               check("hold_timeout", res_timeout, h_tmo);
            end
            if (res_valid && res_ready) begin
               hs_cnt++;
               check("record_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("rec_ch", res_ch, e.ch);
                  check("rec_period", res_period, e.per);
                  check("rec_high", res_high, e.high);
                  check("rec_timeout", res_timeout, e.tmo);
               end
            end
            stall = res_valid && !res_ready;
            h_ch = res_ch;
            h_per = res_period;
            h_high = res_high;
            h_tmo = res_timeout;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, base;
      tick(3);
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_ch", res_ch, 0);
      check("rst_period", res_period, 0);
      check("rst_high", res_high, 0);
      check("rst_timeout", res_timeout, 0);
      sys_rst = 1'b0;
      res_ready = 1'b1;
      tick(2);
      go(2'b00, 8'd4);
      check("zero_mask_busy", busy, 0);

      set_wave(0, 8, 4);
      tick(5);
      exp_q.push_back(lit(0, 32, 16, 1'b0));
      go(2'b01, 8'd4);
      check("busy_rise", busy, 1);
      wait_busy_low(200, "t1_busy_fall");

      set_wave(0, 10, 3);
      set_wave(1, 6, 3);
      tick(5);
      exp_q.push_back(lit(0, 30, 9, 1'b0));
      exp_q.push_back(meas(1, 6, 3, 3));
      go(2'b11, 8'd3);
      tick(5);
      ch_mask = 2'b01;
      n_periods = 8'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_busy_low(400, "t2_busy_fall");

      set_wave(1, 0, 0);
      tick(5);
      exp_q.push_back(lit(1, 0, 0, 1'b1));
      go(2'b10, 8'd2);
      tick();
      k = 0;
      while (!res_valid && k < 300) begin
         tick();
         k++;
      end
      check("tmo_latency", k, 101);
      wait_busy_low(50, "t3_busy_fall");

      res_ready = 1'b0;
      set_wave(0, 8, 4);
      set_wave(1, 6, 3);
      tick(5);
      exp_q.push_back(meas(0, 8, 4, 2));
      exp_q.push_back(meas(1, 6, 3, 2));
      go(2'b11, 8'd2);
      wait_valid(200, "t4_valid");
      base = hs_cnt;
      tick(50);
      check("stall_valid", res_valid, 1);
      check("stall_no_hs", hs_cnt, base);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("one_hs", hs_cnt, base + 1);
      check("valid_drop", res_valid, 0);
      wait_valid(200, "t4_valid2");
      tick(10);
      check("stall2_no_hs", hs_cnt, base + 1);
      res_ready = 1'b1;
      wait_busy_low(50, "t4_busy_fall");

      continuous = 1'b1;
      base = hs_cnt;
      repeat (4) exp_q.push_back(meas(1, 6, 3, 2));
      go(2'b10, 8'd2);
      k = 0;
      while (hs_cnt < base + 3 && k < 500) begin
         tick();
         k++;
      end
      check("cont_three", hs_cnt, base + 3);
      continuous = 1'b0;
      wait_busy_low(200, "t5_busy_fall");
      check("cont_total", hs_cnt, base + 4);

      set_wave(0, 10, 5);
      tick(5);
      go(2'b01, 8'd8);
      tick(40);
      sys_rst = 1'b1;
      tick();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_period", res_period, 0);
      sys_rst = 1'b0;
      set_wave(0, 8, 4);
      tick(5);
      exp_q.push_back(lit(0, 32, 16, 1'b0));
      go(2'b01, 8'd4);
      wait_busy_low(200, "t6_busy_fall");

      set_wave(0, 7, 2);
      tick(5);
      exp_q.push_back(meas(0, 7, 2, 0));
      go(2'b01, 8'd0);
      wait_busy_low(200, "t7_busy_fall");

      tick(3);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
